// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the fetch stage's control inputs, instruction-memory
// port and IF/ID register outputs.
//   master : the fetch stage (drives imem_addr and the if_id_* outputs)
//   slave  : the surroundings (control unit, instruction ROM, decode stage)
// Signals:
//   PCSel, target_pc, IF_Flush, Load_Hazard : redirect/flush/hazard controls
//   imem_rdata, imem_ready, imem_addr       : instruction memory port
//   if_id_instr, if_id_pc, if_id_pc4,
//   if_id_valid                             : IF/ID register contents
//   stall_cnt, flush_cnt, fetch_cnt         : only with PERF_CNT_EN defined
interface fetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            PCSel;
  logic [XLEN-1:0] target_pc;
  logic            IF_Flush;
  logic            Load_Hazard;
  logic [31:0]     imem_rdata;
  logic            imem_ready;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     if_id_instr;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_pc4;
  logic            if_id_valid;
`ifdef PERF_CNT_EN
  logic [31:0]     stall_cnt;
  logic [31:0]     flush_cnt;
  logic [31:0]     fetch_cnt;
`endif

  modport master (
    input  PCSel, target_pc, IF_Flush, Load_Hazard, imem_rdata, imem_ready,
    output imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid
`ifdef PERF_CNT_EN
    , output stall_cnt, flush_cnt, fetch_cnt
`endif
  );

  modport slave (
    output PCSel, target_pc, IF_Flush, Load_Hazard, imem_rdata, imem_ready,
    input  imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid
`ifdef PERF_CNT_EN
    , input stall_cnt, flush_cnt, fetch_cnt
`endif
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register of the
// 5-stage RV32I core. Holds the PC, presents it as the instruction-memory
// address and registers the fetched word for decode.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : fetch_stage_if.master (controls, imem port, IF/ID outputs)
// Per-cycle priority: redirect (PCSel / IF_Flush) > load-use bubble >
// imem wait state > normal fetch. Every non-fetch cycle loads a bubble.
// Optional: define PERF_CNT_EN to add stall/flush/fetch event counters.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic [XLEN-1:0] ifpc4_q, ifpc4_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] pc_plus4;
  logic            redirect;
  logic            stall;
  logic            fetch;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign redirect = bus.PCSel | bus.IF_Flush;
  assign stall    = ~redirect & (bus.Load_Hazard | ~bus.imem_ready);
  assign fetch    = ~redirect & ~stall;

  // Bubbles keep if_id_pc/if_id_pc4; only a real fetch updates them.
  always_comb begin
    pc_d    = pc_q;
    instr_d = NOP_INSTR;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    valid_d = 1'b0;
    if (bus.PCSel) begin
      // Low two bits dropped: no misaligned-fetch trap in this core.
      pc_d = bus.target_pc & ~XLEN'(3);
    end else if (bus.IF_Flush) begin
      pc_d = pc_plus4;
    end else if (fetch) begin
      pc_d    = pc_plus4;
      instr_d = bus.imem_rdata;
      ifpc_d  = pc_q;
      ifpc4_d = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= RESET_PC;
      ifpc4_q <= RESET_PC + XLEN'(4);
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = ifpc_q;
  assign bus.if_id_pc4   = ifpc4_q;
  assign bus.if_id_valid = valid_q;

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, fetch_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      if (stall)    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (fetch)    fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) bus ();

  fetch_stage #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Instruction ROM: word content is a fixed function of the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hDEAD_0003;
  endfunction

  assign bus.imem_rdata = rom(bus.imem_addr);

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  // Reference model: architectural state updated from the rule table.
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4;
  logic        m_valid;
  logic [31:0] m_stall, m_flush, m_fetch;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0; m_instr <= 32'h13; m_ifpc <= 32'h0; m_ifpc4 <= 32'h4;
      m_valid <= 1'b0; m_stall <= 0; m_flush <= 0; m_fetch <= 0;
    end else begin
      m_instr <= 32'h13;
      m_valid <= 1'b0;
      if (bus.PCSel) begin
        m_pc <= {bus.target_pc[31:2], 2'b00};
        m_flush <= m_flush + 1;
      end else if (bus.IF_Flush) begin
        m_pc <= m_pc + 32'd4;
        m_flush <= m_flush + 1;
      end else if (bus.Load_Hazard || !bus.imem_ready) begin
        m_stall <= m_stall + 1;
      end else begin
        m_instr <= rom(m_pc);
        m_ifpc  <= m_pc;
        m_ifpc4 <= m_pc + 32'd4;
        m_valid <= 1'b1;
        m_pc    <= m_pc + 32'd4;
        m_fetch <= m_fetch + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_id_instr", bus.if_id_instr, m_instr);
    chk("if_id_pc", bus.if_id_pc, m_ifpc);
    chk("if_id_pc4", bus.if_id_pc4, m_ifpc4);
    chk("if_id_valid", {31'b0, bus.if_id_valid}, {31'b0, m_valid});
`ifdef PERF_CNT_EN
    chk("stall_cnt", bus.stall_cnt, m_stall);
    chk("flush_cnt", bus.flush_cnt, m_flush);
    chk("fetch_cnt", bus.fetch_cnt, m_fetch);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic set_in(input logic sel, input logic fl, input logic lh,
                        input logic rdy, input logic [31:0] tgt);
    bus.PCSel = sel; bus.IF_Flush = fl; bus.Load_Hazard = lh;
    bus.imem_ready = rdy; bus.target_pc = tgt;
  endtask

  // Mixed directed vectors: {PCSel, IF_Flush, Load_Hazard, imem_ready, target}
  logic [35:0] vecs [12] = '{
    {4'b0001, 32'h0}, {4'b0011, 32'h0}, {4'b0001, 32'h0}, {4'b0000, 32'h0},
    {4'b1001, 32'h3A6}, {4'b0001, 32'h0}, {4'b0101, 32'h0}, {4'b0001, 32'h0},
    {4'b1110, 32'h500}, {4'b0010, 32'h0}, {4'b0001, 32'h0}, {4'b0001, 32'h0}
  };

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    #1 rst = 1'b1;
    @(negedge clk);
    compare_model();
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_instr", bus.if_id_instr, 32'h13);
    chk("rst_pc4", bus.if_id_pc4, 32'h4);
    chk("rst_valid", {31'b0, bus.if_id_valid}, 32'h0);
    rst = 1'b0;

    cyc();
    chk("c1_ifpc", bus.if_id_pc, 32'h0);
    chk("c1_valid", {31'b0, bus.if_id_valid}, 32'h1);
    chk("c1_instr", bus.if_id_instr, 32'hDEAD_0003);
    cyc(); cyc();
    chk("c3_ifpc", bus.if_id_pc, 32'h8);
    chk("c3_pc4", bus.if_id_pc4, 32'hC);
    cyc();
    chk("pc_0x10", bus.imem_addr, 32'h10);

    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h100); cyc();
    chk("redir_pc", bus.imem_addr, 32'h100);
    chk("redir_valid", {31'b0, bus.if_id_valid}, 32'h0);
    chk("redir_instr", bus.if_id_instr, 32'h13);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0); cyc();
    chk("redir_ifpc", bus.if_id_pc, 32'h100);

    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h20); cyc();
    chk("pc_0x20", bus.imem_addr, 32'h20);
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h0); cyc();
    chk("lh_pc_hold", bus.imem_addr, 32'h20);
    chk("lh_bubble", {31'b0, bus.if_id_valid}, 32'h0);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0); cyc();
    chk("lh_refetch_pc", bus.if_id_pc, 32'h20);
    chk("lh_refetch_valid", {31'b0, bus.if_id_valid}, 32'h1);

    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h40); cyc();
    chk("prio_pc", bus.imem_addr, 32'h40);
    chk("prio_bubble", {31'b0, bus.if_id_valid}, 32'h0);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0); cyc();
    chk("prio_ifpc", bus.if_id_pc, 32'h40);
    chk("prio_valid", {31'b0, bus.if_id_valid}, 32'h1);

    set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h0); cyc();
    chk("flush_pc", bus.imem_addr, 32'h48);
    chk("flush_ifpc_hold", bus.if_id_pc, 32'h40);

    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wait_pc", bus.imem_addr, 32'h48);
      chk("wait_bubble", {31'b0, bus.if_id_valid}, 32'h0);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0); cyc();
    chk("wait_done_ifpc", bus.if_id_pc, 32'h48);

    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h203); cyc();
    chk("align_pc", bus.imem_addr, 32'h200);

    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC); cyc();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0); cyc();
    chk("wrap_ifpc", bus.if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", bus.if_id_pc4, 32'h0);
    chk("wrap_pc", bus.imem_addr, 32'h0);
    chk("wrap_instr", bus.if_id_instr, 32'h2152_FFFF);

    foreach (vecs[k]) begin
      set_in(vecs[k][35], vecs[k][34], vecs[k][33], vecs[k][32], vecs[k][31:0]);
      cyc();
    end

    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); cyc();
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_instr", bus.if_id_instr, 32'h13);
    chk("arst_ifpc", bus.if_id_pc, 32'h0);
    chk("arst_pc4", bus.if_id_pc4, 32'h4);
    chk("arst_valid", {31'b0, bus.if_id_valid}, 32'h0);
`ifdef PERF_CNT_EN
    chk("arst_stall_cnt", bus.stall_cnt, 32'h0);
    chk("arst_flush_cnt", bus.flush_cnt, 32'h0);
    chk("arst_fetch_cnt", bus.fetch_cnt, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    compare_model();
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h0); cyc();
    chk("post_rst_flush_pc", bus.imem_addr, 32'h4);
`ifdef PERF_CNT_EN
    chk("post_rst_flush_cnt", bus.flush_cnt, 32'h1);
`endif
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0); cyc();
    chk("post_rst_fetch", bus.if_id_pc, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
